// File: rtl/alu8085_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu8085_pkg
// Purpose  : Shared ALU op encoding, opcode/funct fields, flag indices and
//            execute-stage FSM states for the 8085-style pipeline.
// Revision : 1.0
// ============================================================================
package alu8085_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_ADC = 4'd5,
        OP_SBB = 4'd6,
        OP_CMP = 4'd7,
        OP_MUL = 4'd8,
        OP_ILL = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_MDONE = 2'd2
    } state_e;

    localparam logic [4:0] c_OPC_RTYPE_MAX = 5'd3;
    localparam logic [4:0] c_OPC_EXT       = 5'd4;
    localparam logic [4:0] c_OPC_AND       = 5'd9;
    localparam logic [4:0] c_OPC_OR        = 5'd10;
    localparam logic [4:0] c_OPC_XOR       = 5'd11;
    localparam logic [4:0] c_OPC_CMP       = 5'd13;

    localparam logic [4:0] c_FN_AND        = 5'd6;
    localparam logic [4:0] c_FN_OR         = 5'd7;
    localparam logic [4:0] c_FN_XOR        = 5'd8;
    localparam logic [4:0] c_FN_MUL        = 5'd13;
    localparam logic [4:0] c_FN_ADC        = 5'd14;
    localparam logic [4:0] c_FN_SBB        = 5'd15;
    localparam logic [4:0] c_FN_EXT_OR     = 5'd12;

    // Flag vector layout is {S,Z,AC,P,CY}
    localparam int c_FLAG_CY = 0;
    localparam int c_FLAG_P  = 1;
    localparam int c_FLAG_AC = 2;
    localparam int c_FLAG_Z  = 3;
    localparam int c_FLAG_S  = 4;

    function automatic logic even_parity8(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode_8085.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode_8085
// Purpose  : Combinational opcode/funct to ALU-op decoder with write-back
//            enable and illegal-encoding detection.
// Revision : 1.0
// ============================================================================
module alu_decode_8085
    import alu8085_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [4:0] opcode,
    input  logic [4:0] funct,
    output alu_op_e    op,
    output logic       wb_en,
    output logic       illegal
);

    always_comb begin
        op = OP_ILL;
        if (opcode <= c_OPC_RTYPE_MAX) begin
            case (funct)
                5'd0, 5'd1, 5'd4:        op = OP_ADD;
                5'd2, 5'd3, 5'd5, 5'd9:  op = OP_SUB;
                c_FN_AND:                op = OP_AND;
                c_FN_OR:                 op = OP_OR;
                c_FN_XOR:                op = OP_XOR;
                c_FN_MUL:                op = MUL_EN ? OP_MUL : OP_ILL;
                c_FN_ADC:                op = OP_ADC;
                c_FN_SBB:                op = OP_SBB;
                default:                 op = OP_ILL;
            endcase
        end else begin
            case (opcode)
                5'd5, 5'd6, 5'd15, 5'd16, 5'd17, 5'd18: op = OP_ADD;
                5'd7, 5'd8, 5'd12:                      op = OP_SUB;
                c_OPC_AND:                              op = OP_AND;
                c_OPC_OR:                               op = OP_OR;
                c_OPC_XOR:                              op = OP_XOR;
                c_OPC_CMP:                              op = OP_CMP;
                c_OPC_EXT: begin
                    if (funct == c_FN_EXT_OR)
                        op = OP_OR;
                    else if (funct == 5'd10 || funct == 5'd11)
                        op = OP_XOR;
                    else
                        op = OP_ILL;
                end
                default: op = OP_ILL;
            endcase
        end
    end

    assign illegal = (op == OP_ILL);
    assign wb_en   = (op != OP_ILL) && (op != OP_CMP);

endmodule
`default_nettype wire

// File: rtl/alu_ex_stage_8085.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage_8085
// Purpose  : Execute stage: decode, ALU datapath, shift-add multiplier,
//            persistent flag register and valid/ready output register.
// Revision : 1.0
// ============================================================================
module alu_ex_stage_8085
    import alu8085_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [4:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic [4:0]        flags,
    output logic              wb_en,
    output logic              illegal,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(DATA_W) + 1;

    state_e                r_state;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_result;
    logic [DATA_W-1:0]     r_result_hi;
    logic [4:0]            r_flags;
    logic                  r_wb_en;
    logic                  r_illegal;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]     r_mplier;
    logic [2*DATA_W-1:0]   r_prod;
    logic [c_CNT_W-1:0]    r_cnt;

    alu_op_e               w_op;
    logic                  w_wb_en;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_out_free;
    logic                  w_is_sub;
    logic                  w_ci;
    logic [DATA_W-1:0]     w_b_eff;
    logic [DATA_W:0]       w_sum;
    logic [4:0]            w_nib;
    logic [DATA_W-1:0]     w_res;
    logic                  w_cy;
    logic                  w_ac;
    logic [4:0]            w_new_flags;
    logic [2*DATA_W-1:0]   w_prod_next;
    logic [4:0]            w_mul_flags;

    alu_decode_8085 #(
        .MUL_EN (MUL_EN)
    ) u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .op      (w_op),
        .wb_en   (w_wb_en),
        .illegal (w_illegal)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == ST_IDLE) && w_out_free && !flush;
    assign w_accept   = in_valid && in_ready;

    // Subtracts run as a + ~b + carry, so the borrow is the inverted carry
    assign w_is_sub = (w_op == OP_SUB) || (w_op == OP_SBB) || (w_op == OP_CMP);
    always_comb begin
        w_ci = 1'b0;
        case (w_op)
            OP_ADC:         w_ci = r_flags[c_FLAG_CY];
            OP_SUB, OP_CMP: w_ci = 1'b1;
            OP_SBB:         w_ci = !r_flags[c_FLAG_CY];
            default:        w_ci = 1'b0;
        endcase
    end

    assign w_b_eff = w_is_sub ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + (DATA_W+1)'(w_ci);
    assign w_nib   = {1'b0, a[3:0]} + {1'b0, w_b_eff[3:0]} + 5'(w_ci);

    always_comb begin
        w_res = w_sum[DATA_W-1:0];
        w_cy  = 1'b0;
        w_ac  = 1'b0;
        case (w_op)
            OP_ADD, OP_ADC: begin
                w_cy = w_sum[DATA_W];
                w_ac = w_nib[4];
            end
            OP_SUB, OP_SBB, OP_CMP: w_cy = !w_sum[DATA_W];
            OP_AND: begin
                w_res = a & b;
                w_ac  = 1'b1;
            end
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            default: w_res = '0;
        endcase
    end

    assign w_new_flags = {w_res[DATA_W-1], (w_res == '0), w_ac,
                          even_parity8(w_res[7:0]), w_cy};

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_flags = {r_prod[DATA_W-1], (r_prod == '0), 1'b0,
                          even_parity8(r_prod[7:0]),
                          (r_prod[2*DATA_W-1:DATA_W] != '0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_wb_en     <= 1'b0;
            r_illegal   <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_op == OP_MUL) begin
                            r_mcand  <= {{DATA_W{1'b0}}, a};
                            r_mplier <= b;
                            r_prod   <= '0;
                            r_cnt    <= '0;
                            r_state  <= ST_MUL;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_wb_en     <= w_wb_en;
                            r_illegal   <= w_illegal;
                            if (!w_illegal)
                                r_flags <= w_new_flags;
                        end
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_W'(DATA_W - 1))
                        r_state <= ST_MDONE;
                end
                ST_MDONE: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_result    <= r_prod[DATA_W-1:0];
                        r_result_hi <= r_prod[2*DATA_W-1:DATA_W];
                        r_flags     <= w_mul_flags;
                        r_wb_en     <= 1'b1;
                        r_illegal   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign wb_en     = r_wb_en;
    assign illegal   = r_illegal;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage_8085.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ex_stage_8085
// Purpose  : Scoreboard bench for alu_ex_stage_8085 with an independent
//            reference model of decode, arithmetic and flags.
// Revision : 1.0
// ============================================================================
module tb_alu_ex_stage_8085;

    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] fl;
        logic       wb;
        logic       ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [4:0]    opcode, funct;
    logic [DW-1:0] a, b;
    logic          in_ready, out_valid, wb_en, illegal, busy;
    logic [DW-1:0] result, result_hi;
    logic [4:0]    flags;
    logic          n_in_ready, n_out_valid, n_wb_en, n_illegal, n_busy;
    logic [DW-1:0] n_result, n_result_hi;
    logic [4:0]    n_flags;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [4:0] tb_flags;

    always #5 clk = ~clk;

    alu_ex_stage_8085 #(.DATA_W(DW), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .opcode(opcode), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .flags(flags), .wb_en(wb_en),
        .illegal(illegal), .busy(busy)
    );

    alu_ex_stage_8085 #(.DATA_W(DW), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(n_in_ready), .opcode(opcode), .funct(funct), .a(a), .b(b),
        .out_valid(n_out_valid), .out_ready(out_ready), .result(n_result),
        .result_hi(n_result_hi), .flags(n_flags), .wb_en(n_wb_en),
        .illegal(n_illegal), .busy(n_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [4:0] opc, input logic [4:0] fn,
                                   input logic [7:0] x, input logic [7:0] y,
                                   input logic [4:0] fin);
        int   kind;
        int   ci, s, p;
        exp_t e;
        logic cy, ac;
        logic [7:0] r;
        // kind: 0 add 1 sub 2 and 3 or 4 xor 5 mul 6 adc 7 sbb 8 cmp 9 illegal
        kind = 9;
        if (opc <= 5'd3) begin
            case (fn)
                5'd0, 5'd1, 5'd4:       kind = 0;
                5'd2, 5'd3, 5'd5, 5'd9: kind = 1;
                5'd6:  kind = 2;
                5'd7:  kind = 3;
                5'd8:  kind = 4;
                5'd13: kind = 5;
                5'd14: kind = 6;
                5'd15: kind = 7;
                default: kind = 9;
            endcase
        end else begin
            case (opc)
                5'd5, 5'd6, 5'd15, 5'd16, 5'd17, 5'd18: kind = 0;
                5'd7, 5'd8, 5'd12: kind = 1;
                5'd9:  kind = 2;
                5'd10: kind = 3;
                5'd11: kind = 4;
                5'd13: kind = 8;
                5'd4:  kind = (fn == 5'd12) ? 3 : ((fn == 5'd10 || fn == 5'd11) ? 4 : 9);
                default: kind = 9;
            endcase
        end
        e = '0;
        cy = 1'b0;
        ac = 1'b0;
        r  = 8'h00;
        case (kind)
            0, 6: begin
                ci = (kind == 6) ? int'(fin[0]) : 0;
                s  = int'(x) + int'(y) + ci;
                r  = s[7:0];
                cy = (s > 255);
                ac = ((int'(x[3:0]) + int'(y[3:0]) + ci) > 15);
            end
            1, 7, 8: begin
                ci = (kind == 7) ? int'(fin[0]) : 0;
                s  = int'(x) - int'(y) - ci;
                r  = s[7:0];
                cy = (int'(x) < int'(y) + ci);
            end
            2: begin r = x & y; ac = 1'b1; end
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                p  = int'(x) * int'(y);
                r  = p[7:0];
                e.hi = p[15:8];
            end
            default: r = 8'h00;
        endcase
        e.res = r;
        e.wb  = (kind != 8) && (kind != 9);
        e.ill = (kind == 9);
        if (kind == 9)
            e.fl = fin;
        else if (kind == 5)
            e.fl = {r[7], (e.hi == 8'h00 && r == 8'h00), 1'b0, ~^r, (e.hi != 8'h00)};
        else
            e.fl = {r[7], (r == 8'h00), ac, ~^r, cy};
        return e;
    endfunction

    // Caller and task both stand at posedge+1; waited counts stalled cycles
    task automatic issue(input logic [4:0] opc, input logic [4:0] fn,
                         input logic [7:0] x, input logic [7:0] y,
                         input bit expect_out, output int waited);
        exp_t e;
        in_valid = 1'b1;
        opcode   = opc;
        funct    = fn;
        a        = x;
        b        = y;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            e = model(opc, fn, x, y, tb_flags);
            sb.push_back(e);
            tb_flags = e.fl;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result",    32'(result),    32'(e.res));
                chk("sb_result_hi", 32'(result_hi), 32'(e.hi));
                chk("sb_flags",     32'(flags),     32'(e.fl));
                chk("sb_wb_en",     32'(wb_en),     32'(e.wb));
                chk("sb_illegal",   32'(illegal),   32'(e.ill));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] tbl [0:23];
        int w, cnt, rdy_bad;
        tbl = '{{5'd0,5'd1},  {5'd1,5'd4},  {5'd2,5'd2},  {5'd3,5'd3},
                {5'd1,5'd5},  {5'd2,5'd9},  {5'd5,5'd0},  {5'd16,5'd0},
                {5'd8,5'd0},  {5'd12,5'd0}, {5'd9,5'd0},  {5'd4,5'd12},
                {5'd4,5'd10}, {5'd4,5'd11}, {5'd11,5'd0}, {5'd3,5'd7},
                {5'd0,5'd8},  {5'd2,5'd14}, {5'd3,5'd15}, {5'd13,5'd0},
                {5'd1,5'd13}, {5'd20,5'd0}, {5'd4,5'd3},  {5'd0,5'd20}};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct = '0; a = '0; b = '0;
        tb_flags = 5'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_wb_en",     32'(wb_en),     32'd0);
        chk("rst_illegal",   32'(illegal),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;

        issue(5'd0, 5'd0, 8'h3A, 8'hC6, 1'b1, w);
        @(negedge clk);
        chk("add_flags_direct", 32'(flags), 32'b01111);
        @(posedge clk); #1;
        issue(5'd7,  5'd0, 8'h05, 8'h07, 1'b1, w);
        issue(5'd13, 5'd0, 8'h05, 8'h07, 1'b1, w);
        @(negedge clk);
        chk("cmp_wb_en_direct", 32'(wb_en), 32'd0);
        chk("cmp_flags_direct", 32'(flags), 32'b10001);
        @(posedge clk); #1;

        issue(5'd0, 5'd0,  8'hFF, 8'h01, 1'b1, w);
        chk("b2b_ready_add", 32'(w), 32'd0);
        issue(5'd0, 5'd14, 8'h00, 8'h00, 1'b1, w);
        chk("b2b_ready_adc", 32'(w), 32'd0);
        @(negedge clk);
        chk("adc_result_direct", 32'(result), 32'h01);
        @(posedge clk); #1;

        issue(5'd0, 5'd13, 8'hFF, 8'hFF, 1'b1, w);
        @(negedge clk);
        chk("nomul_illegal", 32'(n_illegal),   32'd1);
        chk("nomul_valid",   32'(n_out_valid), 32'd1);
        cnt = 0; rdy_bad = 0;
        while (busy && cnt < 64) begin
            cnt++;
            if (in_ready) rdy_bad++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 32'(cnt), 32'(DW + 1));
        chk("mul_in_ready_low", 32'(rdy_bad), 32'd0);
        chk("mul_result_direct", {16'h0, result_hi, result}, 32'hFE01);
        @(posedge clk); #1;

        idle(2);
        out_ready = 1'b0;
        issue(5'd0, 5'd6, 8'hF0, 8'h3C, 1'b1, w);
        repeat (5) begin
            @(negedge clk);
            chk("bp_result",   32'(result),            32'h30);
            chk("bp_ac",       32'(flags[2]),          32'd1);
            chk("bp_valid",    32'(out_valid),         32'd1);
            chk("bp_in_ready", 32'(in_ready),          32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_clear", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        issue(5'd10, 5'd0, 8'h12, 8'h34, 1'b1, w);
        chk("bp_next_accept", 32'(w), 32'd0);

        issue(5'd31, 5'd0, 8'h12, 8'h34, 1'b1, w);

        issue(5'd0, 5'd13, 8'h12, 8'h34, 1'b0, w);
        idle(2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",     32'(busy),      32'd0);
        chk("flush_valid",    32'(out_valid), 32'd0);
        chk("flush_flags",    32'(flags),     32'(tb_flags));
        chk("flush_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        issue(5'd0, 5'd14, 8'h7F, 8'h80, 1'b1, w);

        for (int i = 0; i < 40; i++) begin
            logic [9:0] ent;
            ent = tbl[$urandom_range(0, 23)];
            issue(ent[9:5], ent[4:0], 8'($urandom), 8'($urandom), 1'b1, w);
        end
        idle(2);

        issue(5'd0, 5'd13, 8'hFF, 8'hFF, 1'b0, w);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        tb_flags = 5'b0;
        @(negedge clk);
        chk("rst_mid_mul_zero",
            {7'h0, out_valid, result, result_hi, flags, wb_en, illegal, busy},
            32'd0);
        @(posedge clk); #1;
        issue(5'd0, 5'd14, 8'h10, 8'h01, 1'b1, w);
        idle(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_ex_stage_8085.md
Name: alu_ex_stage_8085

Overview:
Parametrised execute stage for the 8085-style pipeline. It combines ALU-control decode (opcode/funct to ALU op) with the datapath, a persistent 8085 flag register and a registered output under a valid/ready handshake.
It adds ADC/SBB/CMP, XOR, a multi-cycle shift-add multiply, illegal-op detection and a pipeline flush.
It sits between the decode/register-read stage and writeback.

Parameters:
DATA_W, 8, operand/result width; must be >= 8.
MUL_EN, 1, when 1 multiply is implemented; when 0 the multiply encoding decodes as illegal.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  operation offered.
in_ready  output  1  stage can accept.
opcode  input  5  instruction opcode.
funct  input  5  function field; R-type only.
a  input  DATA_W  operand A.
b  input  DATA_W  operand B.
out_valid  output  1  output register holds a result.
out_ready  input  1  downstream accepts.
result  output  DATA_W  ALU result; low half for MUL.
result_hi  output  DATA_W  MUL high half; 0 for all other ops.
flags  output  5  {S,Z,AC,P,CY} flag register.
wb_en  output  1  result must be written back.
illegal  output  1  the op in the output register was undecodable.
busy  output  1  multiply in progress.

Behaviour:
- Decode. R-type means opcode 0..3.
  - ADD: R-type with funct 0/1/4, or opcode 5/6/15/16/17/18.
  - SUB: R-type with funct 2/3/5/9, or opcode 7/8/12.
  - AND: R-type with funct 6, or opcode 9.
  - OR: R-type with funct 7, or opcode 4 with funct 12, or opcode 10.
  - XOR: R-type with funct 8, or opcode 4 with funct 10/11, or opcode 11.
  - MUL: R-type with funct 13.
  - ADC: R-type with funct 14.
  - SBB: R-type with funct 15.
  - CMP: opcode 13.
  - Any other encoding is ILLEGAL.
- Accept. An op is accepted when in_valid && in_ready. in_ready = state==IDLE && (!out_valid || out_ready) && !flush.
- Single-cycle ops: out_valid is high the cycle after acceptance (latency 1). Flags update on the same edge, so a back-to-back ADC/SBB sees the new CY.
- FSM states: IDLE, MUL, MDONE.
  - IDLE to MUL on accepting a MUL; operands are latched and the counter is cleared.
  - MUL runs DATA_W shift-add iterations, then moves to MDONE.
  - MDONE writes the output register when !out_valid || out_ready, then returns to IDLE.
  - MUL latency is DATA_W+1 cycles with no backpressure. busy = state != IDLE.
- Arithmetic: all results are truncated to DATA_W.
  - SUB/SBB/CMP compute a + ~b + !(borrow-in). CY is the borrow (1 when a < b+cin).
  - ADC/SBB use the current CY flag as carry/borrow-in.
  - CMP updates flags, with wb_en=0.
- Flags:
  - Z = result==0 (for MUL, the full 2*DATA_W product==0).
  - S = result MSB.
  - P = even parity of result[7:0].
  - AC = carry out of bit 3 for ADD/ADC, 0 for SUB/SBB/CMP. AND sets AC=1; OR/XOR set AC=0; MUL sets AC=0.
  - CY = 0 for logical ops; for MUL, CY = result_hi != 0.
- ILLEGAL op: out_valid=1, illegal=1, result=0, wb_en=0, flags unchanged.
- Backpressure: while out_valid && !out_ready, every output holds stable. A finished MUL waits in MDONE.
- Output handshake: when out_ready is high and nothing new is loaded, out_valid clears the cycle after.
- Flush: clears out_valid and aborts MUL/MDONE back to IDLE. The aborted MUL never updates flags; flags from already-completed ops are kept. No acceptance happens in the flush cycle.
- Reset: dominates flush.
  - State=IDLE, out_valid=0.
  - result, result_hi and flags = 0; wb_en=0, illegal=0, busy=0.
  - in_ready=1 in the cycle after reset deasserts.

Decomposition:
- Shared package alu8085_pkg:
  - 4-bit ALU op enum: ADD, SUB, AND, OR, XOR, ADC, SBB, CMP, MUL, ILL.
  - opcode/funct localparams.
  - flag bit indices.
  - FSM state enum.
- One natural sub-module: alu_decode_8085, a combinational opcode/funct-to-op decoder that also outputs wb_en and illegal. The FSM, datapath and flags stay in the top module.

Test Plan:
- ADD opcode0/funct0, a=0x3A, b=0xC6 -> next cycle result=0x00, Z=1, CY=1, AC=1, P=1, S=0, wb_en=1.
- SUB opcode7, a=0x05, b=0x07 -> result=0xFE, CY=1, S=1, Z=0, P=0. CMP opcode13 with the same operands gives the same flags with wb_en=0.
- Back-to-back: ADD 0xFF+0x01 (result 0x00, CY=1), then ADC funct14 0x00+0x00 -> result 0x01, CY=0. in_ready stays high throughout.
- MUL funct13, 0xFF*0xFF -> busy for DATA_W+1 cycles, in_ready=0 throughout, then result=0x01, result_hi=0xFE, CY=1. With MUL_EN=0, the same stimulus gives illegal=1.
- Hold out_ready=0 for 5 cycles after an AND of 0xF0 with 0x3C -> result stays 0x30, AC=1, in_ready=0. Release -> out_valid clears and the next op is accepted.
- opcode 31 -> illegal=1, wb_en=0, flags unchanged. Flush 3 cycles into a MUL -> no out_valid, flags unchanged, IDLE next cycle. rst mid-MUL -> all outputs 0.
